hpf_mux: RTL and testbench
==========================

HPF_MUX -- requirements
Module: hpf_mux

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the unsigned input sample width.
REQ-002 The block SHALL have parameter SHR, default 4, the time-constant shift; cutoff Fc/Fs = -ln(1 - 2^-SHR)/(2*pi).
REQ-003 The block SHALL have parameter CH_N, default 4, the number of time-multiplexed channels; CH_W = max(1, clog2(CH_N)).
REQ-004 The block SHALL have port clk_i, input, 1 bit, the single clock.
REQ-005 The block SHALL have port rst_n_i, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port clr_i, input, 1 bit, a synchronous clear of all channel state.
REQ-007 The block SHALL have port in_valid_i, input, 1 bit, which is high when an input sample is offered.
REQ-008 The block SHALL have port in_ready_o, output, 1 bit, which is high when the block accepts a sample.
REQ-009 The block SHALL have port in_ch_i, input, CH_W bits, the channel index of the input sample.
REQ-010 The block SHALL have port in_data_i, input, DATA_W bits, the unsigned input sample.
REQ-011 The block SHALL have port out_valid_o, output, 1 bit, which is high when a result is offered.
REQ-012 The block SHALL have port out_ready_i, input, 1 bit, which is high when the downstream logic takes the result.
REQ-013 The block SHALL have port out_ch_o, output, CH_W bits, the channel tag of the result.
REQ-014 The block SHALL have port out_data_o, output, DATA_W+1 bits, the signed high-pass result.

Function
REQ-015 The block SHALL hold one DATA_W-bit unsigned low-pass state lp[c] per channel, and each state SHALL change only on that channel's samples.
REQ-016 The FSM SHALL have three states (IDLE, CALC, OUT), and in_ready_o SHALL be 1 only in IDLE.
REQ-017 In IDLE, a transfer SHALL occur when in_valid_i & in_ready_o; the block SHALL capture x and ch and go to CALC.
REQ-018 In CALC, the block SHALL compute hp = x - lp[ch] (signed, DATA_W+1 bits) and write lp[ch] <= lp[ch] + (hp >>> SHR), using an arithmetic (floor) shift.
REQ-019 The lp update SHALL never wrap, because it stays within [0, 2^DATA_W-1] by construction; no saturation logic SHALL be added.
REQ-020 In CALC, the block SHALL register out_data_o = hp and out_ch_o = ch, then go to OUT.
REQ-021 In OUT, out_valid_o SHALL be 1, and out_data_o and out_ch_o SHALL hold stable until out_ready_i is 1.
REQ-022 On the OUT cycle where out_ready_i is 1, the block SHALL return to IDLE.
REQ-023 Timing: a sample accepted at cycle N SHALL produce out_valid_o at N+2, and in_ready_o SHALL be high again at N+3 at the earliest; peak throughput is 1 sample per 3 cycles.
REQ-024 If in_ch_i >= CH_N, the sample SHALL be accepted, no state SHALL be written, no output SHALL be produced, and the FSM SHALL return to IDLE on the next cycle.
REQ-025 When clr_i is 1 in any state, the block SHALL zero every lp[c], force IDLE, and drop any in-flight sample; in_ready_o SHALL be 0 in that cycle, and clr takes priority over a simultaneous transfer.
REQ-026 When out_valid_o is 0, out_data_o and out_ch_o SHALL be 0.

Reset
REQ-027 While rst_n_i is 0, the block SHALL immediately force the FSM to IDLE, all lp[c] to 0, out_valid_o to 0, out_data_o to 0, out_ch_o to 0 and in_ready_o to 0.
REQ-028 After release, in_ready_o SHALL go to 1 on the first clk_i edge; an assertion mid-operation SHALL discard the in-flight sample without emitting it.

Structure
REQ-029 Package filt_pkg SHALL hold the FSM state enum (IDLE, CALC, OUT) and a function computing CH_W from CH_N.
REQ-030 The per-channel state storage SHALL be one sub-module, hpf_state_rf (a CH_N x DATA_W register file with one read port and one write port, async active-low reset, sync clear); everything else SHALL be in hpf_mux.

Verification (DATA_W=8, SHR=2, CH_N=4)
REQ-031 Step test: ch0 x=200 three times -> outputs 200, 150, 113, with lp[0] = 50, 87, 115.
REQ-032 Negative step: after REQ-031, ch0 x=0 -> output -115 (9'h18D), with lp[0] = 86.
REQ-033 Isolation/range test: ch1 x=100 -> output 100, with lp[0] unchanged; ch=5 is not reachable with CH_W=2, so also run CH_N=3 with ch=3 -> accepted, no output.
REQ-034 Backpressure test: hold out_ready_i=0 for 5 cycles in OUT -> out_data_o and out_ch_o stable, in_ready_o=0; the next in_ready_o comes 1 cycle after the handshake.
REQ-035 Clear test: clr_i during CALC -> no output; a following ch0 x=200 -> output 200.
REQ-036 Reset test: rst_n_i low mid-OUT -> out_valid_o=0 immediately, and all states read back 0.

Source files
------------

// File: rtl/filt_pkg.sv
// rtl/filt_pkg.sv - shared FSM state type and channel-width helper for the high-pass mux
package filt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } hpf_state_e;

  // Channel index width; a single-channel build still carries a 1-bit tag.
  function automatic int calc_ch_w(input int ch_n);
    return (ch_n <= 1) ? 1 : $clog2(ch_n);
  endfunction

endpackage

// File: rtl/hpf_state_rf.sv
// rtl/hpf_state_rf.sv - per-channel low-pass state register file, one read and one write port
module hpf_state_rf
  import filt_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int CH_N   = 4,
  localparam int CH_W   = calc_ch_w(CH_N)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic [CH_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] mem_q [CH_N];

  // Storage update: reset and clear zero every entry, clear wins over a write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < CH_N; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < CH_N; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      for (int i = 0; i < CH_N; i++) begin
        if (wr_addr_i == CH_W'(i)) mem_q[i] <= wr_data_i;
      end
    end
  end

  // Read mux; addresses beyond CH_N-1 read as zero instead of indexing past the array.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < CH_N; i++) begin
      if (rd_addr_i == CH_W'(i)) rd_data_o = mem_q[i];
    end
  end

endmodule

// File: rtl/hpf_mux.sv
// rtl/hpf_mux.sv - time-multiplexed first-order high-pass filter with valid/ready handshakes
module hpf_mux
  import filt_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int SHR    = 4,
  parameter  int CH_N   = 4,
  localparam int CH_W   = calc_ch_w(CH_N)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clr_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [CH_W-1:0]          in_ch_i,
  input  logic [DATA_W-1:0]        in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [CH_W-1:0]          out_ch_o,
  output logic signed [DATA_W:0]   out_data_o
);

  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CH_N);

  hpf_state_e                state_q;
  logic                      rdy_q;
  logic [DATA_W-1:0]         x_q;
  logic [CH_W-1:0]           ch_q;
  logic [DATA_W-1:0]         lp_rd;
  logic [DATA_W-1:0]         lp_nxt;
  logic signed [DATA_W:0]    hp;
  logic signed [DATA_W:0]    hp_shr;
  logic                      ch_ok;
  logic                      lp_we;

  // Ready is registered so it stays low through reset; a clear masks it in its own cycle.
  assign in_ready_o = rdy_q & ~clr_i;

  // Filter datapath for the captured sample; the lp sum cannot leave [0, 2^DATA_W-1].
  always_comb begin
    ch_ok  = ({1'b0, ch_q} < CH_LIM);
    hp     = $signed({1'b0, x_q}) - $signed({1'b0, lp_rd});
    hp_shr = hp >>> SHR;
    lp_nxt = DATA_W'({1'b0, lp_rd} + hp_shr);
    lp_we  = (state_q == CALC) && ch_ok && !clr_i;
  end

  hpf_state_rf #(
    .DATA_W (DATA_W),
    .CH_N   (CH_N)
  ) u_state_rf (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (clr_i),
    .rd_addr_i (ch_q),
    .rd_data_o (lp_rd),
    .wr_en_i   (lp_we),
    .wr_addr_i (ch_q),
    .wr_data_i (lp_nxt)
  );

  // Control FSM with registered handshake and result outputs; clear drops any in-flight sample.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      x_q         <= '0;
      ch_q        <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
    end else if (clr_i) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i && rdy_q) begin
            x_q     <= in_data_i;
            ch_q    <= in_ch_i;
            rdy_q   <= 1'b0;
            state_q <= CALC;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        CALC: begin
          if (ch_ok) begin
            out_valid_o <= 1'b1;
            out_data_o  <= hp;
            out_ch_o    <= ch_q;
            state_q     <= OUT;
          end else begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_ch_o    <= '0;
            rdy_q       <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hpf_mux.sv
// tb/tb_hpf_mux.sv - scoreboard bench for hpf_mux with DATA_W=8, SHR=2
module tb_hpf_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clr, in_valid, in_valid3, out_ready;
  logic [1:0] in_ch;
  logic [7:0] in_data;
  logic       in_ready, out_valid, in_ready3, out_valid3;
  logic [1:0] out_ch, out_ch3;
  logic [8:0] out_data, out_data3;

  hpf_mux #(.DATA_W(8), .SHR(2), .CH_N(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ch_i(in_ch), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ch_o(out_ch), .out_data_o(out_data)
  );

  hpf_mux #(.DATA_W(8), .SHR(2), .CH_N(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr),
    .in_valid_i(in_valid3), .in_ready_o(in_ready3), .in_ch_i(in_ch), .in_data_i(in_data),
    .out_valid_o(out_valid3), .out_ready_i(out_ready), .out_ch_o(out_ch3), .out_data_o(out_data3)
  );

  typedef struct packed {
    logic [1:0] ch;
    logic [8:0] d;
  } exp_t;

  exp_t sb[$];
  int   lp_m[4];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Output monitor: compares every handshaked result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {out_ch, out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", out_data, e.d);
        check("out_ch", out_ch, e.ch);
      end
    end
    if (!out_valid) check("idle_zero", {out_ch, out_data}, 0);
    else            check("ready_in_out", in_ready, 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] x);
    int t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_ch    = ch;
    in_data  = x;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [8:0] model(input int ch, input int x);
    int hp;
    hp = x - lp_m[ch];
    lp_m[ch] = lp_m[ch] + (hp >>> 2);
    return hp[8:0];
  endfunction

  task automatic send_exp(input logic [1:0] ch, input logic [7:0] x, input logic [8:0] exp);
    logic [8:0] m;
    m = model(ch, x);
    sb.push_back({ch, exp});
    send(ch, x);
  endtask

  task automatic send_model(input logic [1:0] ch, input logic [7:0] x);
    logic [8:0] m;
    m = model(ch, x);
    sb.push_back({ch, m});
    send(ch, x);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 100) begin
      tick();
      t++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [10:0] held;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_valid3 = 1'b0;
    out_ready = 1'b1; in_ch = '0; in_data = '0;
    for (int i = 0; i < 4; i++) lp_m[i] = 0;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", in_ready, 1);

    // Step test with latency checks on the first sample
    sb.push_back({2'd0, 9'd200});
    void'(model(0, 200));
    send(2'd0, 8'd200);
    check("lat_n1_valid", out_valid, 0);
    check("lat_n1_ready", in_ready, 0);
    tick();
    check("lat_n2_valid", out_valid, 1);
    tick();
    check("lat_n3_ready", in_ready, 1);
    send_exp(2'd0, 8'd200, 9'd150);
    send_exp(2'd0, 8'd200, 9'd113);
    // Negative step
    send_exp(2'd0, 8'd0, 9'h18D);
    // Isolation: ch1 fresh, ch0 must still be 86
    send_exp(2'd1, 8'd100, 9'd100);
    send_exp(2'd0, 8'd86, 9'd0);
    drain();

    // Out-of-range channel on the 3-channel instance
    check("r3_ready", in_ready3, 1);
    in_valid3 = 1'b1; in_ch = 2'd3; in_data = 8'd99;
    tick();
    in_valid3 = 1'b0;
    check("r3_n1_valid", out_valid3, 0);
    tick();
    check("r3_n2_valid", out_valid3, 0);
    check("r3_n2_ready", in_ready3, 1);
    in_valid3 = 1'b1; in_ch = 2'd2; in_data = 8'd50;
    tick();
    in_valid3 = 1'b0;
    tick();
    check("r3_valid", out_valid3, 1);
    check("r3_data", out_data3, 50);
    check("r3_ch", out_ch3, 2);
    tick();

    // Backpressure
    out_ready = 1'b0;
    send_exp(2'd2, 8'd40, 9'd40);
    tick();
    check("bp_valid", out_valid, 1);
    held = {out_ch, out_data};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {out_ch, out_data}, held);
      check("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_ready_after", in_ready, 1);
    check("bp_valid_after", out_valid, 0);

    // Clear during CALC
    send(2'd0, 8'd123);
    clr = 1'b1;
    #1;
    check("clr_in_ready", in_ready, 0);
    tick();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) lp_m[i] = 0;
    repeat (3) begin
      check("clr_no_out", out_valid, 0);
      tick();
    end
    send_exp(2'd0, 8'd200, 9'd200);
    send_exp(2'd2, 8'd40, 9'd40);
    drain();

    // Random traffic against the model
    for (int i = 0; i < 24; i++) begin
      send_model(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    drain();

    // Reset asserted mid-OUT
    out_ready = 1'b0;
    send(2'd1, 8'd77);
    tick();
    check("rstm_valid_pre", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstm_valid", out_valid, 0);
    check("rstm_data", out_data, 0);
    check("rstm_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) lp_m[i] = 0;
    tick();
    for (int c = 0; c < 4; c++) send_exp(2'(c), 8'(8'h5A + c), 9'(9'h5A + c));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
